prog_loader: RTL and testbench

Serial program loader for the 8-bit computer. It receives a framed program image over a UART line (8N1, LSB first) and writes the 16 bytes into the computer's RAM through the programming-mode port (`prog_mode`, address, data). After a checksum check it releases programming mode and pulses the CPU reset so the new program starts from address 0. It drives the RAM's programming port, so it replaces manual switch entry.

---
 rtl/prog_loader.sv | 230 +++++++++++++++++++++++
 tb/tb_prog_loader.sv | 170 +++++++++++++++++
 2 files changed

// File: rtl/prog_loader.sv
// prog_loader: UART-fed program loader. Receives a header, 16 data bytes and a
// checksum byte. Writes the data bytes into RAM through the programming port,
// then releases programming mode and pulses the CPU reset.
module prog_loader #(
  parameter int unsigned CLKS_PER_BIT = 104,
  parameter int unsigned RST_CYCLES   = 4,
  parameter logic [7:0]  HEADER       = 8'h55
) (
  input  logic       fastClk,
  input  logic       rst,
  input  logic       rx,
  output logic       prog_mode,
  output logic [3:0] prog_addr,
  output logic [7:0] prog_data,
  output logic       prog_we,
  output logic       cpu_rst,
  output logic       busy,
  output logic       done,
  output logic       error
);

  localparam int unsigned CW       = $clog2(CLKS_PER_BIT);
  localparam int unsigned HALF_BIT = CLKS_PER_BIT / 2;
  localparam int unsigned RW       = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;

  typedef enum logic [1:0] {R_IDLE, R_START, R_DATA, R_STOP} rx_state_t;
  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_CHECK, S_RESET, S_DONE, S_ERROR} ld_state_t;

  // ---------------- UART receiver ----------------
  logic            rx_s1, rx_s2, rx_d;
  rx_state_t       rx_state_q, rx_state_d;
  logic [CW-1:0]   rx_cnt_q, rx_cnt_d;
  logic [2:0]      rx_bit_q, rx_bit_d;
  logic [7:0]      rx_shift_q, rx_shift_d;
  logic            byte_valid_q, byte_valid_d;
  logic            frame_err_q, frame_err_d;

  // Two-flop synchronizer plus one delayed copy for falling-edge detection
  always_ff @(posedge fastClk) begin
    if (rst) begin
      rx_s1 <= 1'b1;
      rx_s2 <= 1'b1;
      rx_d  <= 1'b1;
    end else begin
      rx_s1 <= rx;
      rx_s2 <= rx_s1;
      rx_d  <= rx_s2;
    end
  end

  // Receiver state register
  always_ff @(posedge fastClk) begin
    if (rst) begin
      rx_state_q   <= R_IDLE;
      rx_cnt_q     <= '0;
      rx_bit_q     <= '0;
      rx_shift_q   <= '0;
      byte_valid_q <= 1'b0;
      frame_err_q  <= 1'b0;
    end else begin
      rx_state_q   <= rx_state_d;
      rx_cnt_q     <= rx_cnt_d;
      rx_bit_q     <= rx_bit_d;
      rx_shift_q   <= rx_shift_d;
      byte_valid_q <= byte_valid_d;
      frame_err_q  <= frame_err_d;
    end
  end

  // Receiver next state: start qualify at half bit, then sample mid-bit
  always_comb begin
    rx_state_d   = rx_state_q;
    rx_cnt_d     = rx_cnt_q;
    rx_bit_d     = rx_bit_q;
    rx_shift_d   = rx_shift_q;
    byte_valid_d = 1'b0;
    frame_err_d  = 1'b0;
    case (rx_state_q)
      R_IDLE: begin
        if (rx_d && !rx_s2) begin
          rx_state_d = R_START;
          rx_cnt_d   = '0;
        end
      end
      R_START: begin
        if (rx_cnt_q == CW'(HALF_BIT - 1)) begin
          rx_cnt_d = '0;
          rx_bit_d = '0;
          rx_state_d = rx_s2 ? R_IDLE : R_DATA;
        end else begin
          rx_cnt_d = CW'(rx_cnt_q + CW'(1));
        end
      end
      R_DATA: begin
        if (rx_cnt_q == CW'(CLKS_PER_BIT - 1)) begin
          rx_cnt_d   = '0;
          rx_shift_d = {rx_s2, rx_shift_q[7:1]};
          if (rx_bit_q == 3'd7) begin
            rx_state_d = R_STOP;
          end else begin
            rx_bit_d = 3'(rx_bit_q + 3'd1);
          end
        end else begin
          rx_cnt_d = CW'(rx_cnt_q + CW'(1));
        end
      end
      R_STOP: begin
        if (rx_cnt_q == CW'(CLKS_PER_BIT - 1)) begin
          rx_cnt_d     = '0;
          byte_valid_d = rx_s2;
          frame_err_d  = !rx_s2;
          rx_state_d   = R_IDLE;
        end else begin
          rx_cnt_d = CW'(rx_cnt_q + CW'(1));
        end
      end
      default: rx_state_d = R_IDLE;
    endcase
  end

  // ---------------- Loader FSM ----------------
  ld_state_t     state_q, state_d;
  logic [3:0]    count_q, count_d;
  logic [7:0]    csum_q, csum_d;
  logic [RW-1:0] rcnt_q, rcnt_d;
  logic          mode_d, we_d, cpu_rst_d, busy_d, done_d, error_d;
  logic [3:0]    addr_d;
  logic [7:0]    data_d;

  // Loader state and output registers
  always_ff @(posedge fastClk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      count_q   <= '0;
      csum_q    <= '0;
      rcnt_q    <= '0;
      prog_mode <= 1'b0;
      prog_addr <= '0;
      prog_data <= '0;
      prog_we   <= 1'b0;
      cpu_rst   <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      error     <= 1'b0;
    end else begin
      state_q   <= state_d;
      count_q   <= count_d;
      csum_q    <= csum_d;
      rcnt_q    <= rcnt_d;
      prog_mode <= mode_d;
      prog_addr <= addr_d;
      prog_data <= data_d;
      prog_we   <= we_d;
      cpu_rst   <= cpu_rst_d;
      busy      <= busy_d;
      done      <= done_d;
      error     <= error_d;
    end
  end

  // Loader next state: header -> 16 writes -> checksum -> CPU reset pulse
  always_comb begin
    state_d   = state_q;
    count_d   = count_q;
    csum_d    = csum_q;
    rcnt_d    = rcnt_q;
    mode_d    = prog_mode;
    addr_d    = prog_addr;
    data_d    = prog_data;
    we_d      = 1'b0;
    cpu_rst_d = cpu_rst;
    done_d    = done;
    error_d   = error;
    case (state_q)
      S_IDLE, S_DONE, S_ERROR: begin
        if (byte_valid_q && (rx_shift_q == HEADER)) begin
          state_d = S_LOAD;
          mode_d  = 1'b1;
          done_d  = 1'b0;
          error_d = 1'b0;
          count_d = '0;
          csum_d  = '0;
        end
      end
      S_LOAD: begin
        if (frame_err_q) begin
          state_d = S_ERROR;
          error_d = 1'b1;
        end else if (byte_valid_q) begin
          we_d    = 1'b1;
          addr_d  = count_q;
          data_d  = rx_shift_q;
          csum_d  = 8'(csum_q + rx_shift_q);
          count_d = 4'(count_q + 4'd1);
          if (count_q == 4'd15) begin
            state_d = S_CHECK;
          end
        end
      end
      S_CHECK: begin
        if (frame_err_q) begin
          state_d = S_ERROR;
          error_d = 1'b1;
        end else if (byte_valid_q) begin
          if (rx_shift_q == csum_q) begin
            state_d   = S_RESET;
            mode_d    = 1'b0;
            cpu_rst_d = 1'b1;
            rcnt_d    = '0;
          end else begin
            state_d = S_ERROR;
            error_d = 1'b1;
          end
        end
      end
      S_RESET: begin
        if (rcnt_q == RW'(RST_CYCLES - 1)) begin
          state_d   = S_DONE;
          cpu_rst_d = 1'b0;
          done_d    = 1'b1;
        end else begin
          rcnt_d = RW'(rcnt_q + RW'(1));
        end
      end
      default: state_d = S_IDLE;
    endcase
    busy_d = (state_d == S_LOAD) || (state_d == S_CHECK);
  end

endmodule

// File: tb/tb_prog_loader.sv
// Self-checking bench for prog_loader: table of whole frames plus hand-written
// noise and reset-mid-load sequences.
module tb_prog_loader;

  localparam int unsigned CPB   = 16;
  localparam int unsigned RST_C = 4;

  logic       fastClk = 1'b0;
  logic       rst     = 1'b1;
  logic       rx      = 1'b1;
  logic       prog_mode, prog_we, cpu_rst, busy, done, error;
  logic [3:0] prog_addr;
  logic [7:0] prog_data;

  prog_loader #(.CLKS_PER_BIT(CPB), .RST_CYCLES(RST_C), .HEADER(8'h55)) dut (
    .fastClk(fastClk), .rst(rst), .rx(rx),
    .prog_mode(prog_mode), .prog_addr(prog_addr), .prog_data(prog_data),
    .prog_we(prog_we), .cpu_rst(cpu_rst), .busy(busy), .done(done), .error(error)
  );

  always #5 fastClk = ~fastClk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Write / reset-pulse monitor
  logic [3:0] wr_addr [32];
  logic [7:0] wr_data [32];
  int         wr_count   = 0;
  int         rst_cycles = 0;
  logic       prev_cpu_rst = 1'b0;
  logic       prev_mode    = 1'b0;

  always @(negedge fastClk) begin
    if (prog_we) begin
      chk("mode_during_we", 32'(prog_mode), 32'd1);
      if (wr_count < 32) begin
        wr_addr[wr_count] = prog_addr;
        wr_data[wr_count] = prog_data;
      end
      wr_count++;
    end
    if (cpu_rst) rst_cycles++;
    if (cpu_rst && !prev_cpu_rst) begin
      chk("mode_falls_with_cpu_rst", 32'({prev_mode, prog_mode}), 32'b10);
      chk("done_low_during_cpu_rst", 32'(done), 32'd0);
    end
    if (!cpu_rst && prev_cpu_rst)
      chk("done_after_cpu_rst", 32'(done), 32'd1);
    prev_cpu_rst = cpu_rst;
    prev_mode    = prog_mode;
  end

  task automatic send_bit(input logic level);
    rx = level;
    repeat (CPB) @(negedge fastClk);
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop);
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(b[i]);
    send_bit(stop);
    send_bit(1'b1);
  endtask

  typedef struct {
    logic [7:0] base;
    logic       incr;
    logic [7:0] csum;
    int         ferr_idx;
    int         exp_writes;
    logic       exp_done;
    logic       exp_error;
    int         exp_rst;
  } vec_t;

  vec_t vecs [5];

  function automatic logic [7:0] data_of(input vec_t v, input int i);
    return v.incr ? 8'(v.base + 8'(i)) : v.base;
  endfunction

  task automatic apply_frame(input int id, input vec_t v);
    logic [7:0] b;
    wr_count   = 0;
    rst_cycles = 0;
    send_byte(8'h55, 1'b1);
    for (int i = 0; i < 16; i++) begin
      b = data_of(v, i);
      if (i == v.ferr_idx) begin
        send_byte(b, 1'b0);
        break;
      end
      send_byte(b, 1'b1);
    end
    if (v.ferr_idx < 0) send_byte(v.csum, 1'b1);
    repeat (3 * CPB) @(negedge fastClk);
    chk($sformatf("v%0d_writes", id), 32'(wr_count), 32'(v.exp_writes));
    for (int i = 0; i < v.exp_writes && i < wr_count && i < 32; i++) begin
      chk($sformatf("v%0d_addr%0d", id, i), 32'(wr_addr[i]), 32'(i));
      chk($sformatf("v%0d_data%0d", id, i), 32'(wr_data[i]), 32'(data_of(v, i)));
    end
    chk($sformatf("v%0d_rst_cycles", id), 32'(rst_cycles), 32'(v.exp_rst));
    chk($sformatf("v%0d_done", id), 32'(done), 32'(v.exp_done));
    chk($sformatf("v%0d_error", id), 32'(error), 32'(v.exp_error));
    chk($sformatf("v%0d_prog_mode", id), 32'(prog_mode), 32'(v.exp_error));
    chk($sformatf("v%0d_busy_cpu_rst", id), 32'({busy, cpu_rst}), 32'd0);
    chk($sformatf("v%0d_hold", id), 32'({prog_addr, prog_data}),
        32'({4'(v.exp_writes - 1), data_of(v, v.exp_writes - 1)}));
  endtask

  initial begin
    // base, incr, csum, ferr_idx, writes, done, error, rst_cycles
    vecs[0] = '{8'h10, 1'b1, 8'h78, -1, 16, 1'b1, 1'b0, 4};  // good frame
    vecs[1] = '{8'h10, 1'b1, 8'h77, -1, 16, 1'b0, 1'b1, 0};  // bad checksum
    vecs[2] = '{8'h10, 1'b1, 8'h78, -1, 16, 1'b1, 1'b0, 4};  // recovery
    vecs[3] = '{8'h55, 1'b0, 8'h50, -1, 16, 1'b1, 1'b0, 4};  // header as data
    vecs[4] = '{8'h10, 1'b1, 8'h78,  5,  5, 1'b0, 1'b1, 0};  // framing error

    repeat (3) @(negedge fastClk);
    chk("reset_outputs",
        32'({prog_mode, prog_addr, prog_data, prog_we, cpu_rst, busy, done, error}), 32'd0);
    rst = 1'b0;
    repeat (4) @(negedge fastClk);

    // Noise before the header: no writes, nothing leaves IDLE
    wr_count = 0;
    send_byte(8'h00, 1'b1);
    send_byte(8'hAA, 1'b1);
    rx = 1'b0;
    repeat (CPB / 4) @(negedge fastClk);
    rx = 1'b1;
    repeat (2 * CPB) @(negedge fastClk);
    chk("noise_writes", 32'(wr_count), 32'd0);
    chk("noise_state", 32'({prog_mode, busy, done, error}), 32'd0);

    for (int k = 0; k < 5; k++) apply_frame(k, vecs[k]);

    // Reset mid-load after 8 data bytes
    wr_count = 0;
    send_byte(8'h55, 1'b1);
    for (int i = 0; i < 8; i++) send_byte(8'(8'h10 + 8'(i)), 1'b1);
    chk("midload_writes", 32'(wr_count), 32'd8);
    chk("midload_busy_mode", 32'({busy, prog_mode}), 32'b11);
    rst = 1'b1;
    @(negedge fastClk);
    rst = 1'b0;
    chk("midload_reset_outputs",
        32'({prog_mode, prog_addr, prog_data, prog_we, cpu_rst, busy, done, error}), 32'd0);
    wr_count = 0;
    for (int i = 8; i < 16; i++) send_byte(8'(8'h10 + 8'(i)), 1'b1);
    send_byte(8'h78, 1'b1);
    repeat (2 * CPB) @(negedge fastClk);
    chk("after_reset_writes", 32'(wr_count), 32'd0);
    chk("after_reset_state", 32'({prog_mode, busy, done, error}), 32'd0);
    apply_frame(5, vecs[0]);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
